// File: rtl/stream_intf_pkg.sv
// Shared types for the DMA <-> PEA streaming bridge.
//   stream_dir_e   : channel direction (read = DMA->PEA, write = PEA->DMA)
//   stream_state_e : per-channel transfer FSM state
//   stream_cfg_t   : per-channel configuration view {dir, len, thr}; the
//                    fields are sized for the widest supported LEN_W/CNT_W
//                    and narrower values are zero-extended into them.
package stream_intf_pkg;

    localparam int STREAM_LEN_MAX_W = 32;
    localparam int STREAM_THR_MAX_W = 8;

    typedef enum logic {
        STREAM_RD = 1'b0,
        STREAM_WR = 1'b1
    } stream_dir_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } stream_state_e;

    typedef struct packed {
        stream_dir_e                 dir;
        logic [STREAM_LEN_MAX_W-1:0] len;
        logic [STREAM_THR_MAX_W-1:0] thr;
    } stream_cfg_t;

endpackage

// File: rtl/stream_ch_buf.sv
// Per-channel DEPTH x DATA_W registered FIFO (non-fall-through).
//   clk, rst : clock, asynchronous active-high reset (empties the buffer)
//   push     : write request with data (dropped when full unless a pop
//              frees the slot in the same cycle)
//   pop      : read request (ignored when empty)
//   head     : storage word at the read pointer, combinational
//   occ      : occupancy 0..DEPTH; full / empty flags
module stream_ch_buf #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic [DATA_W-1:0]       data,
    input  logic                    pop,
    output logic [DATA_W-1:0]       head,
    output logic [$clog2(DEPTH):0]  occ,
    output logic                    full,
    output logic                    empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              do_push;
    logic              do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    // A same-cycle pop frees the slot the push needs.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];
    assign occ     = count;

    // DEPTH is a power of two, so pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= data;
    end

endmodule

// File: rtl/stream_dma_pea_bridge.sv
// Per-channel streaming bridge between DMA hardware-FIFO ports and PEA
// stream ports. Each channel is started with a direction and beat count:
//   read  (DMA->PEA): DMA pushes (prefetch allowed in IDLE), beats are
//                     delivered to the PEA while RUN and the column is ready.
//   write (PEA->DMA): PEA beats are buffered while RUN, then DRAIN waits for
//                     the DMA to pop everything before signalling done.
// Ports: cfg_dir_i/cfg_len_i sampled at start_i; cfg_afull_thr_i (live,
// 0 = DEPTH) sets dma_full_o; dma_push/data_i, dma_pop_i, dma_data_o,
// dma_empty_o, dma_full_o face the DMA; pea_ready_i, pea_valid/data_o,
// pea_valid/data_i face the PEA; busy_o, done_o (one-cycle), ovf_o (sticky,
// cleared by start) report status.
module stream_dma_pea_bridge
    import stream_intf_pkg::*;
#(
    parameter int  N_CH   = 4,
    parameter int  DATA_W = 32,
    parameter int  DEPTH  = 4,
    parameter int  LEN_W  = 16,
    localparam int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [N_CH-1:0]         cfg_dir_i,
    input  logic [N_CH*LEN_W-1:0]   cfg_len_i,
    input  logic [N_CH*CNT_W-1:0]   cfg_afull_thr_i,
    input  logic [N_CH-1:0]         start_i,
    input  logic [N_CH-1:0]         dma_push_i,
    input  logic [N_CH*DATA_W-1:0]  dma_data_i,
    output logic [N_CH-1:0]         dma_full_o,
    input  logic [N_CH-1:0]         dma_pop_i,
    output logic [N_CH*DATA_W-1:0]  dma_data_o,
    output logic [N_CH-1:0]         dma_empty_o,
    input  logic [N_CH-1:0]         pea_ready_i,
    output logic [N_CH-1:0]         pea_valid_o,
    output logic [N_CH*DATA_W-1:0]  pea_data_o,
    input  logic [N_CH-1:0]         pea_valid_i,
    input  logic [N_CH*DATA_W-1:0]  pea_data_i,
    output logic [N_CH-1:0]         busy_o,
    output logic [N_CH-1:0]         done_o,
    output logic [N_CH-1:0]         ovf_o
);

    // Threshold 0 or anything above DEPTH means "full only when full".
    function automatic logic [CNT_W-1:0] eff_thr(input logic [STREAM_THR_MAX_W-1:0] thr);
        if (thr == '0 || thr > STREAM_THR_MAX_W'(DEPTH)) return CNT_W'(DEPTH);
        return thr[CNT_W-1:0];
    endfunction

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        stream_state_e    state_q, state_d;
        stream_dir_e      dir_q, dir_d;
        logic [LEN_W-1:0] len_q, len_d;
        logic [LEN_W-1:0] cnt_q, cnt_d;
        logic             ovf_q, ovf_d;
        logic             done_q, done_d;
        stream_cfg_t      cfg_in;

        logic              buf_push, buf_pop, buf_full, buf_empty;
        logic [DATA_W-1:0] buf_wdata, buf_head;
        logic [CNT_W-1:0]  occ;
        logic              is_wr, rd_beat, wr_beat, ovf_set, drain_done;

        always_comb begin
            cfg_in     = '0;
            cfg_in.dir = stream_dir_e'(cfg_dir_i[c]);
            cfg_in.len = STREAM_LEN_MAX_W'(cfg_len_i[c*LEN_W +: LEN_W]);
            cfg_in.thr = STREAM_THR_MAX_W'(cfg_afull_thr_i[c*CNT_W +: CNT_W]);
        end

        assign is_wr = (dir_q == STREAM_WR);

        stream_ch_buf #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_buf (
            .clk   (clk_i),
            .rst   (rst_i),
            .push  (buf_push),
            .data  (buf_wdata),
            .pop   (buf_pop),
            .head  (buf_head),
            .occ   (occ),
            .full  (buf_full),
            .empty (buf_empty)
        );

        always_comb begin
            state_d    = state_q;
            dir_d      = dir_q;
            len_d      = len_q;
            cnt_d      = cnt_q;
            ovf_d      = ovf_q;
            done_d     = 1'b0;
            buf_push   = 1'b0;
            buf_pop    = 1'b0;
            buf_wdata  = dma_data_i[c*DATA_W +: DATA_W];
            rd_beat    = 1'b0;
            wr_beat    = 1'b0;
            ovf_set    = 1'b0;
            drain_done = 1'b0;

            if (!is_wr) begin
                rd_beat = (state_q == ST_RUN) && !buf_empty && pea_ready_i[c];
                buf_pop = rd_beat;
                if (dma_push_i[c]) begin
                    if (buf_full && !buf_pop) ovf_set  = 1'b1;
                    else                      buf_push = 1'b1;
                end
            end else begin
                buf_pop   = dma_pop_i[c] && !buf_empty;
                buf_wdata = pea_data_i[c*DATA_W +: DATA_W];
                wr_beat   = (state_q == ST_RUN) && pea_valid_i[c] && pea_ready_i[c];
                // A dropped write beat still counts towards the length.
                if (wr_beat) begin
                    if (buf_full && !buf_pop) ovf_set  = 1'b1;
                    else                      buf_push = 1'b1;
                end
            end

            case (state_q)
                ST_IDLE: begin
                    if (start_i[c]) begin
                        ovf_d = 1'b0;
                        if (cfg_in.len == '0) begin
                            done_d = 1'b1;
                        end else begin
                            state_d = ST_RUN;
                            dir_d   = cfg_in.dir;
                            len_d   = cfg_in.len[LEN_W-1:0];
                            cnt_d   = '0;
                        end
                    end
                end
                ST_RUN: begin
                    if (rd_beat || wr_beat) begin
                        cnt_d = cnt_q + LEN_W'(1);
                        if ((cnt_q + LEN_W'(1)) == len_q) begin
                            if (is_wr) begin
                                state_d = ST_DRAIN;
                            end else begin
                                state_d = ST_IDLE;
                                done_d  = 1'b1;
                            end
                        end
                    end
                end
                ST_DRAIN: begin
                    // Done is flagged on the cycle whose pop empties the
                    // buffer (or immediately if it is already empty).
                    if (buf_empty || (occ == CNT_W'(1) && buf_pop)) begin
                        drain_done = 1'b1;
                        state_d    = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase

            if (ovf_set) ovf_d = 1'b1;
        end

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                state_q <= ST_IDLE;
                dir_q   <= STREAM_RD;
                len_q   <= '0;
                cnt_q   <= '0;
                ovf_q   <= 1'b0;
                done_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                dir_q   <= dir_d;
                len_q   <= len_d;
                cnt_q   <= cnt_d;
                ovf_q   <= ovf_d;
                done_q  <= done_d;
            end
        end

        assign pea_valid_o[c]                  = rd_beat;
        assign pea_data_o[c*DATA_W +: DATA_W]  = rd_beat ? buf_head : '0;
        assign dma_full_o[c]                   = !is_wr && (occ >= eff_thr(cfg_in.thr));
        assign dma_empty_o[c]                  = !is_wr || buf_empty;
        assign dma_data_o[c*DATA_W +: DATA_W]  = (is_wr && !buf_empty) ? buf_head : '0;
        assign busy_o[c]                       = (state_q != ST_IDLE);
        assign done_o[c]                       = done_q || drain_done;
        assign ovf_o[c]                        = ovf_q;
    end

endmodule

// File: tb/tb_stream_dma_pea_bridge.sv
// Scoreboard-driven bench for stream_dma_pea_bridge (N_CH=4, DEPTH=4).
module tb_stream_dma_pea_bridge;
    localparam int N_CH = 4, DATA_W = 32, DEPTH = 4, LEN_W = 16, CNT_W = 3;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [N_CH-1:0]        cfg_dir, start, dma_push, dma_pop, pea_ready, pea_vin;
    logic [N_CH*LEN_W-1:0]  cfg_len;
    logic [N_CH*CNT_W-1:0]  cfg_thr;
    logic [N_CH*DATA_W-1:0] dma_din, pea_din, dma_dout, pea_dout;
    logic [N_CH-1:0]        dma_full, dma_empty, pea_vout, busy, done, ovf;

    int checks = 0;
    int errors = 0;
    logic [DATA_W-1:0] exp_q[$];

    stream_dma_pea_bridge #(.N_CH(N_CH), .DATA_W(DATA_W), .DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
        .clk_i(clk), .rst_i(rst),
        .cfg_dir_i(cfg_dir), .cfg_len_i(cfg_len), .cfg_afull_thr_i(cfg_thr),
        .start_i(start),
        .dma_push_i(dma_push), .dma_data_i(dma_din), .dma_full_o(dma_full),
        .dma_pop_i(dma_pop), .dma_data_o(dma_dout), .dma_empty_o(dma_empty),
        .pea_ready_i(pea_ready), .pea_valid_o(pea_vout), .pea_data_o(pea_dout),
        .pea_valid_i(pea_vin), .pea_data_i(pea_din),
        .busy_o(busy), .done_o(done), .ovf_o(ovf)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_inputs();
        cfg_dir = '0; start = '0; dma_push = '0; dma_pop = '0; pea_ready = '0; pea_vin = '0;
        cfg_len = '0; cfg_thr = '0; dma_din = '0; pea_din = '0;
    endtask

    task automatic do_start(input int ch, input bit dir, input int len, input int thr);
        cfg_dir[ch] = dir;
        cfg_len[ch*LEN_W +: LEN_W] = LEN_W'(len);
        cfg_thr[ch*CNT_W +: CNT_W] = CNT_W'(thr);
        start[ch] = 1'b1;
        settle();
        tick();
        start[ch] = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        #2;
        checks++; if (busy !== 4'h0) begin errors++; $display("FAIL reset_busy: got %b want 0000", busy); end
        checks++; if (done !== 4'h0) begin errors++; $display("FAIL reset_done: got %b want 0000", done); end
        checks++; if (ovf !== 4'h0) begin errors++; $display("FAIL reset_ovf: got %b want 0000", ovf); end
        checks++; if (pea_vout !== 4'h0 || dma_full !== 4'h0) begin errors++; $display("FAIL reset_valid_full: got %b/%b want 0000/0000", pea_vout, dma_full); end
        checks++; if (dma_empty !== 4'hF) begin errors++; $display("FAIL reset_empty: got %b want 1111", dma_empty); end
        checks++; if (dma_dout !== '0 || pea_dout !== '0) begin errors++; $display("FAIL reset_data: got %h/%h want 0", dma_dout, pea_dout); end
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_read_basic();
        int delivered = 0, last_cyc = -1, done_cyc = -1, done_cnt = 0;
        logic [DATA_W-1:0] e;
        do_start(0, 1'b0, 5, 3);
        for (int k = 0; k < 3; k++) begin
            dma_push[0] = 1'b1;
            dma_din[0 +: DATA_W] = 32'hA000_0000 + k;
            exp_q.push_back(32'hA000_0000 + k);
            settle();
            checks++; if (dma_full[0] !== 1'b0) begin errors++; $display("FAIL rd_full_below_thr: occ %0d got %b want 0", k, dma_full[0]); end
            tick();
        end
        dma_push[0] = 1'b0;
        settle();
        checks++; if (dma_full[0] !== 1'b1) begin errors++; $display("FAIL rd_full_at_thr: got %b want 1", dma_full[0]); end
        checks++; if (pea_vout[0] !== 1'b0) begin errors++; $display("FAIL rd_valid_not_ready: got %b want 0", pea_vout[0]); end
        tick();
        pea_ready[0] = 1'b1;
        for (int cyc = 0; cyc < 10; cyc++) begin
            dma_push[0] = (cyc == 1 || cyc == 2);
            dma_din[0 +: DATA_W] = 32'hA000_0002 + cyc;
            if (dma_push[0]) exp_q.push_back(32'hA000_0002 + cyc);
            settle();
            if (pea_vout[0]) begin
                e = exp_q.size() > 0 ? exp_q.pop_front() : 32'hDEAD_BEEF;
                checks++; if (pea_dout[0 +: DATA_W] !== e) begin errors++; $display("FAIL rd_data: got %h want %h", pea_dout[0 +: DATA_W], e); end
                delivered++;
                if (delivered == 5) last_cyc = cyc;
            end
            if (done[0]) begin done_cnt++; done_cyc = cyc; end
            tick();
        end
        dma_push[0] = 1'b0;
        pea_ready[0] = 1'b0;
        settle();
        checks++; if (delivered != 5) begin errors++; $display("FAIL rd_count: got %0d want 5", delivered); end
        checks++; if (done_cnt != 1 || done_cyc != last_cyc + 1) begin errors++; $display("FAIL rd_done: got %0d pulses at %0d want 1 at %0d", done_cnt, done_cyc, last_cyc + 1); end
        checks++; if (ovf[0] !== 1'b0 || busy[0] !== 1'b0) begin errors++; $display("FAIL rd_end_state: got ovf %b busy %b want 0 0", ovf[0], busy[0]); end
        checks++; if (pea_dout[0 +: DATA_W] !== '0) begin errors++; $display("FAIL rd_data_idle: got %h want 0", pea_dout[0 +: DATA_W]); end
        exp_q.delete();
    endtask

    task automatic test_write_drain();
        logic [DATA_W-1:0] e;
        do_start(1, 1'b1, 3, 0);
        pea_ready[1] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            pea_vin[1] = 1'b1;
            pea_din[1*DATA_W +: DATA_W] = 32'hB000_0000 + k;
            exp_q.push_back(32'hB000_0000 + k);
            settle();
            if (k == 0) begin
                checks++; if (dma_empty[1] !== 1'b1) begin errors++; $display("FAIL wr_empty_initial: got %b want 1", dma_empty[1]); end
            end
            if (k == 1) begin
                checks++; if (dma_empty[1] !== 1'b0) begin errors++; $display("FAIL wr_empty_latency: got %b want 0", dma_empty[1]); end
            end
            tick();
        end
        // Beats arriving during DRAIN must be ignored.
        for (int k = 0; k < 2; k++) begin
            pea_din[1*DATA_W +: DATA_W] = 32'hBBBB_0000 + k;
            settle();
            checks++; if (busy[1] !== 1'b1 || done[1] !== 1'b0) begin errors++; $display("FAIL wr_drain_hold: got busy %b done %b want 1 0", busy[1], done[1]); end
            tick();
        end
        pea_vin[1] = 1'b0;
        for (int p = 0; p < 3; p++) begin
            dma_pop[1] = 1'b1;
            settle();
            e = exp_q.size() > 0 ? exp_q.pop_front() : 32'hDEAD_BEEF;
            checks++; if (dma_dout[1*DATA_W +: DATA_W] !== e) begin errors++; $display("FAIL wr_data: got %h want %h", dma_dout[1*DATA_W +: DATA_W], e); end
            checks++; if (done[1] !== (p == 2)) begin errors++; $display("FAIL wr_done_pop%0d: got %b want %b", p, done[1], p == 2); end
            tick();
        end
        dma_pop[1] = 1'b0;
        pea_ready[1] = 1'b0;
        settle();
        checks++; if (busy[1] !== 1'b0 || done[1] !== 1'b0 || dma_empty[1] !== 1'b1) begin errors++; $display("FAIL wr_end_state: got busy %b done %b empty %b want 0 0 1", busy[1], done[1], dma_empty[1]); end
        exp_q.delete();
    endtask

    task automatic test_overflow();
        int delivered = 0, done_cnt = 0;
        logic [DATA_W-1:0] e;
        do_start(2, 1'b0, 5, 0);
        for (int k = 0; k < 5; k++) begin
            dma_push[2] = 1'b1;
            dma_din[2*DATA_W +: DATA_W] = 32'hC000_0000 + k;
            if (k < 4) exp_q.push_back(32'hC000_0000 + k);
            settle();
            if (k == 4) begin
                checks++; if (dma_full[2] !== 1'b1) begin errors++; $display("FAIL ovf_full: got %b want 1", dma_full[2]); end
                checks++; if (ovf[2] !== 1'b0) begin errors++; $display("FAIL ovf_early: got %b want 0", ovf[2]); end
            end
            tick();
        end
        dma_push[2] = 1'b0;
        settle();
        checks++; if (ovf[2] !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b want 1", ovf[2]); end
        tick();
        pea_ready[2] = 1'b1;
        for (int cyc = 0; cyc < 8; cyc++) begin
            dma_push[2] = (cyc == 5);
            dma_din[2*DATA_W +: DATA_W] = 32'hC000_0009;
            if (dma_push[2]) exp_q.push_back(32'hC000_0009);
            settle();
            if (pea_vout[2]) begin
                e = exp_q.size() > 0 ? exp_q.pop_front() : 32'hDEAD_BEEF;
                checks++; if (pea_dout[2*DATA_W +: DATA_W] !== e) begin errors++; $display("FAIL ovf_data: got %h want %h", pea_dout[2*DATA_W +: DATA_W], e); end
                delivered++;
            end
            if (done[2]) done_cnt++;
            tick();
        end
        dma_push[2] = 1'b0;
        pea_ready[2] = 1'b0;
        settle();
        checks++; if (delivered != 5 || done_cnt != 1) begin errors++; $display("FAIL ovf_transfer: got %0d beats %0d done want 5 1", delivered, done_cnt); end
        checks++; if (ovf[2] !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b want 1", ovf[2]); end
        do_start(2, 1'b0, 0, 0);
        settle();
        checks++; if (ovf[2] !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b want 0", ovf[2]); end
        tick();
        exp_q.delete();
    endtask

    task automatic test_simultaneous();
        logic [DATA_W-1:0] e;
        do_start(3, 1'b1, 8, 0);
        pea_ready[3] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            pea_vin[3] = 1'b1;
            pea_din[3*DATA_W +: DATA_W] = 32'hD000_0000 + k;
            exp_q.push_back(32'hD000_0000 + k);
            settle();
            tick();
        end
        // Full buffer: push and pop together.
        pea_din[3*DATA_W +: DATA_W] = 32'hD000_0004;
        dma_pop[3] = 1'b1;
        settle();
        e = exp_q.pop_front();
        exp_q.push_back(32'hD000_0004);
        checks++; if (dma_dout[3*DATA_W +: DATA_W] !== e) begin errors++; $display("FAIL sim_full_head: got %h want %h", dma_dout[3*DATA_W +: DATA_W], e); end
        tick();
        pea_vin[3] = 1'b0;
        for (int p = 0; p < 4; p++) begin
            settle();
            e = exp_q.size() > 0 ? exp_q.pop_front() : 32'hDEAD_BEEF;
            checks++; if (dma_dout[3*DATA_W +: DATA_W] !== e) begin errors++; $display("FAIL sim_drain_data: got %h want %h", dma_dout[3*DATA_W +: DATA_W], e); end
            tick();
        end
        dma_pop[3] = 1'b0;
        settle();
        checks++; if (ovf[3] !== 1'b0 || dma_empty[3] !== 1'b1) begin errors++; $display("FAIL sim_full_noovf: got ovf %b empty %b want 0 1", ovf[3], dma_empty[3]); end
        // Empty buffer: push and pop together, the pop is ignored.
        pea_vin[3] = 1'b1;
        dma_pop[3] = 1'b1;
        pea_din[3*DATA_W +: DATA_W] = 32'hD000_0005;
        exp_q.push_back(32'hD000_0005);
        tick();
        dma_pop[3] = 1'b0;
        for (int k = 6; k < 8; k++) begin
            pea_din[3*DATA_W +: DATA_W] = 32'hD000_0000 + k;
            exp_q.push_back(32'hD000_0000 + k);
            settle();
            if (k == 6) begin
                checks++; if (dma_empty[3] !== 1'b0 || dma_dout[3*DATA_W +: DATA_W] !== 32'hD000_0005) begin errors++; $display("FAIL sim_empty_push: got empty %b data %h want 0 d0000005", dma_empty[3], dma_dout[3*DATA_W +: DATA_W]); end
            end
            tick();
        end
        pea_vin[3] = 1'b0;
        for (int p = 0; p < 3; p++) begin
            dma_pop[3] = 1'b1;
            settle();
            e = exp_q.size() > 0 ? exp_q.pop_front() : 32'hDEAD_BEEF;
            checks++; if (dma_dout[3*DATA_W +: DATA_W] !== e || done[3] !== (p == 2)) begin errors++; $display("FAIL sim_final: got %h done %b want %h done %b", dma_dout[3*DATA_W +: DATA_W], done[3], e, p == 2); end
            tick();
        end
        dma_pop[3] = 1'b0;
        pea_ready[3] = 1'b0;
        settle();
        checks++; if (busy[3] !== 1'b0 || ovf[3] !== 1'b0) begin errors++; $display("FAIL sim_end: got busy %b ovf %b want 0 0", busy[3], ovf[3]); end
        exp_q.delete();
    endtask

    task automatic test_len0_and_busy_start();
        int delivered = 0, done_cnt = 0;
        logic [DATA_W-1:0] e;
        do_start(0, 1'b0, 0, 0);
        settle();
        checks++; if (done[0] !== 1'b1 || busy[0] !== 1'b0) begin errors++; $display("FAIL len0_done: got done %b busy %b want 1 0", done[0], busy[0]); end
        tick();
        settle();
        checks++; if (done[0] !== 1'b0 || busy[0] !== 1'b0) begin errors++; $display("FAIL len0_after: got done %b busy %b want 0 0", done[0], busy[0]); end
        tick();
        do_start(0, 1'b0, 2, 0);
        settle();
        checks++; if (busy[0] !== 1'b1) begin errors++; $display("FAIL busy_start: got %b want 1", busy[0]); end
        cfg_len[0 +: LEN_W] = 16'd7;
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        pea_ready[0] = 1'b1;
        for (int cyc = 0; cyc < 6; cyc++) begin
            dma_push[0] = (cyc < 2);
            dma_din[0 +: DATA_W] = 32'hE000_0000 + cyc;
            if (dma_push[0]) exp_q.push_back(32'hE000_0000 + cyc);
            settle();
            if (pea_vout[0]) begin
                e = exp_q.size() > 0 ? exp_q.pop_front() : 32'hDEAD_BEEF;
                checks++; if (pea_dout[0 +: DATA_W] !== e) begin errors++; $display("FAIL busy_data: got %h want %h", pea_dout[0 +: DATA_W], e); end
                delivered++;
            end
            if (done[0]) done_cnt++;
            tick();
        end
        dma_push[0] = 1'b0;
        pea_ready[0] = 1'b0;
        settle();
        checks++; if (delivered != 2 || done_cnt != 1 || busy[0] !== 1'b0) begin errors++; $display("FAIL busy_ignored: got %0d beats %0d done busy %b want 2 1 0", delivered, done_cnt, busy[0]); end
        exp_q.delete();
    endtask

    task automatic test_reset_mid();
        do_start(1, 1'b0, 8, 0);
        pea_ready[1] = 1'b1;
        for (int cyc = 0; cyc < 3; cyc++) begin
            dma_push[1] = (cyc < 2);
            dma_din[1*DATA_W +: DATA_W] = 32'hF000_0000 + cyc;
            tick();
        end
        pea_ready[1] = 1'b0;
        dma_push[1] = 1'b1;
        tick();
        dma_push[1] = 1'b0;
        pea_ready[1] = 1'b1;
        rst = 1'b1;
        #1;
        checks++; if (busy !== 4'h0 || pea_vout !== 4'h0 || done !== 4'h0) begin errors++; $display("FAIL rstmid_ctrl: got busy %b valid %b done %b want 0", busy, pea_vout, done); end
        checks++; if (dma_empty !== 4'hF || ovf !== 4'h0 || dma_full !== 4'h0) begin errors++; $display("FAIL rstmid_flags: got empty %b ovf %b full %b want 1111 0 0", dma_empty, ovf, dma_full); end
        tick();
        rst = 1'b0;
        settle();
        checks++; if (done !== 4'h0) begin errors++; $display("FAIL rstmid_nodone: got %b want 0000", done); end
        tick();
        exp_q.delete();
        do_start(1, 1'b0, 2, 0);
        pea_ready[1] = 1'b1;
        dma_push[1] = 1'b1;
        dma_din[1*DATA_W +: DATA_W] = 32'h1234_0000;
        settle();
        checks++; if (pea_vout[1] !== 1'b0) begin errors++; $display("FAIL post_rst_lat0: got %b want 0", pea_vout[1]); end
        tick();
        dma_din[1*DATA_W +: DATA_W] = 32'h1234_0001;
        settle();
        checks++; if (pea_vout[1] !== 1'b1 || pea_dout[1*DATA_W +: DATA_W] !== 32'h1234_0000) begin errors++; $display("FAIL post_rst_lat1: got %b %h want 1 12340000", pea_vout[1], pea_dout[1*DATA_W +: DATA_W]); end
        tick();
        dma_push[1] = 1'b0;
        settle();
        checks++; if (pea_vout[1] !== 1'b1 || pea_dout[1*DATA_W +: DATA_W] !== 32'h1234_0001) begin errors++; $display("FAIL post_rst_beat2: got %b %h want 1 12340001", pea_vout[1], pea_dout[1*DATA_W +: DATA_W]); end
        tick();
        settle();
        checks++; if (done[1] !== 1'b1 || busy[1] !== 1'b0) begin errors++; $display("FAIL post_rst_done: got done %b busy %b want 1 0", done[1], busy[1]); end
        tick();
        pea_ready[1] = 1'b0;
    endtask

    initial begin
        test_reset();
        test_read_basic();
        test_write_drain();
        test_overflow();
        test_simultaneous();
        test_len0_and_busy_start();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
